// File: rtl/sev7seg_pkg.sv
// Shared types and defaults for the 7-segment scan controller.
package sev7seg_pkg;

    localparam int NIB_W              = 4;
    localparam int SEV7SEG_ON_CYCLES  = 50000;
    localparam int SEV7SEG_GAP_CYCLES = 500;

    typedef enum logic {
        GAP = 1'b0,
        ON  = 1'b1
    } scan_state_e;

    // Slot counter width: holds up to max(on, gap)-1, never narrower than 1 bit.
    function automatic int cnt_width(input int on_cycles, input int gap_cycles);
        int longest;
        longest = (on_cycles > gap_cycles) ? on_cycles : gap_cycles;
        return (longest > 1) ? $clog2(longest) : 1;
    endfunction

endpackage

// File: rtl/sev7seg_scan.sv
// Time-multiplexed scan controller for a common-anode 7-segment display.
// Double-buffered value; pending data is promoted only when digit 0 lights,
// so a frame never mixes old and new nibbles.
// Optional build macro SEV7SEG_SCAN_LZB_EN enables leading-zero blanking.
//
// state | meaning
// GAP   | all anodes off between digits (anti-ghosting dead time)
// ON    | anode idx lit, digit/dp taken from the active buffer
module sev7seg_scan
    import sev7seg_pkg::*;
#(
    parameter int NDIG       = 4,
    parameter int ON_CYCLES  = SEV7SEG_ON_CYCLES,
    parameter int GAP_CYCLES = SEV7SEG_GAP_CYCLES
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    load,
    input  logic [NIB_W*NDIG-1:0]   value,
    input  logic [NDIG-1:0]         dp_in,
    output logic [NIB_W-1:0]        digit,
    output logic [NDIG-1:0]         an_n,
    output logic                    dp_n,
    output logic                    frame_start
);

    localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int CNT_W = cnt_width(ON_CYCLES, GAP_CYCLES);

    localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NDIG - 1);

    typedef logic [NDIG-1:0][NIB_W-1:0] nib_vec_t;

    scan_state_e       state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              enter_on;

    nib_vec_t          act_q, act_d;
    logic [NDIG-1:0]   act_dp_q, act_dp_d;
    nib_vec_t          pend_q, pend_d;
    logic [NDIG-1:0]   pend_dp_q, pend_dp_d;
    logic              pend_valid_q, pend_valid_d;

    logic [NIB_W-1:0]  digit_q, digit_d;
    logic [NDIG-1:0]   an_n_q, an_n_d;
    logic              dp_n_q, dp_n_d;
    logic              fs_q, fs_d;
    logic              blank;

    // Next state, slot index and slot counter; enter_on flags any edge that lands in ON.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        enter_on = 1'b0;
        if (!en) begin
            state_d = GAP;
            idx_d   = '0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                GAP: begin
                    if (cnt_q == GAP_LAST) begin
                        state_d  = ON;
                        cnt_d    = '0;
                        enter_on = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ON: begin
                    if (cnt_q == ON_LAST) begin
                        idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
                        cnt_d = '0;
                        if (GAP_CYCLES == 0) begin
                            state_d  = ON;
                            enter_on = 1'b1;
                        end else begin
                            state_d = GAP;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            endcase
        end
    end

    // Pending/active buffers; a load on the promotion edge bypasses pending.
    always_comb begin
        act_d        = act_q;
        act_dp_d     = act_dp_q;
        pend_d       = pend_q;
        pend_dp_d    = pend_dp_q;
        pend_valid_d = pend_valid_q;
        if (load) begin
            pend_d       = value;
            pend_dp_d    = dp_in;
            pend_valid_d = 1'b1;
        end
        if (enter_on && (idx_d == '0)) begin
            if (load) begin
                act_d    = value;
                act_dp_d = dp_in;
            end else if (pend_valid_q) begin
                act_d    = pend_q;
                act_dp_d = pend_dp_q;
            end
            pend_valid_d = 1'b0;
        end
    end

    // Output look-ahead: outputs are registered from the state being entered.
    always_comb begin
`ifdef SEV7SEG_SCAN_LZB_EN
        blank = (idx_d != '0);
        for (int i = 0; i < NDIG; i++) begin
            if ((i >= int'(idx_d)) && ((act_d[i] != '0) || act_dp_d[i])) begin
                blank = 1'b0;
            end
        end
`else
        blank = 1'b0;
`endif
        an_n_d  = '1;
        dp_n_d  = 1'b1;
        digit_d = digit_q;
        fs_d    = enter_on && (idx_d == '0);
        if (state_d == ON) begin
            digit_d = act_d[idx_d];
            dp_n_d  = ~act_dp_d[idx_d];
            if (!blank) begin
                an_n_d[idx_d] = 1'b0;
            end
        end
    end

    // State, buffer and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= GAP;
            idx_q        <= '0;
            cnt_q        <= '0;
            act_q        <= '0;
            act_dp_q     <= '0;
            pend_q       <= '0;
            pend_dp_q    <= '0;
            pend_valid_q <= 1'b0;
            digit_q      <= '0;
            an_n_q       <= '1;
            dp_n_q       <= 1'b1;
            fs_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            act_q        <= act_d;
            act_dp_q     <= act_dp_d;
            pend_q       <= pend_d;
            pend_dp_q    <= pend_dp_d;
            pend_valid_q <= pend_valid_d;
            digit_q      <= digit_d;
            an_n_q       <= an_n_d;
            dp_n_q       <= dp_n_d;
            fs_q         <= fs_d;
        end
    end

    assign digit       = digit_q;
    assign an_n        = an_n_q;
    assign dp_n        = dp_n_q;
    assign frame_start = fs_q;

endmodule
